rom_fetch_ctrl: RTL and testbench

Instruction fetch sequencer that drives the combinational instruction ROM read port and presents instructions to decode through a valid/ready handshake.
- Owns the fetch PC and issues at most one ROM read per cycle.
- Captures each {pc, inst, err} into a small flushable prefetch buffer.
- Handles redirects (branch/jump/trap), fetch-enable gating, sticky halt, and out-of-range fetch detection.

---
 rtl/rom_fetch_ctrl_pkg.sv | 43 ++++
 rtl/rom_fetch_ctrl_fetch_buf.sv | 96 +++++++++
 rtl/rom_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Platform macros fall back to the values below when the build does not supply them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 16'h1000
`endif
`ifndef ROM_SIZE
`define ROM_SIZE 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

package rom_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [`ADDR_WIDTH-1:0] pc;
      logic [`INST_WIDTH-1:0] inst;
      logic                   err;
   } fetch_entry_t;

   localparam logic [`ADDR_WIDTH-1:0] ROM_BYTES  = `ADDR_WIDTH'(`ROM_SIZE * 4);
   localparam logic [`ADDR_WIDTH-1:0] PC_STEP    = `ADDR_WIDTH'(3'd4);
   localparam logic [`ADDR_WIDTH-1:0] ALIGN_MASK = {{(`ADDR_WIDTH-2){1'b1}}, 2'b00};
   localparam fetch_entry_t           ENTRY_ZERO = '{pc: {`ADDR_WIDTH{1'b0}}, inst: `DATA_ZERO, err: 1'b0};

   // Subtraction is only meaningful once pc is known to be at or above the base.
   function automatic logic pc_in_rom(input logic [`ADDR_WIDTH-1:0] pc);
      return (pc >= `ADDR_INIT) && ((pc - `ADDR_INIT) < ROM_BYTES);
   endfunction

endpackage

// File: rtl/rom_fetch_ctrl_fetch_buf.sv
// Flushable prefetch FIFO of fetch entries; flush overrides push and pop.
// Head reads as all-zero whenever the buffer is empty.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 16'h1000
`endif
`ifndef ROM_SIZE
`define ROM_SIZE 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module rom_fetch_ctrl_fetch_buf
   import rom_fetch_ctrl_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  fetch_entry_t     i_entry,
   output logic [CNT_W-1:0] o_count,
   output fetch_entry_t     o_head
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_pop_s  = i_pop && (count_q != {CNT_W{1'b0}});
      do_push_s = i_push && ((count_q != DEPTH_C) || do_pop_s);
      if (i_flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = i_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= ENTRY_ZERO;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_head  = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : ENTRY_ZERO;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues ROM reads and feeds
// decode through a prefetch buffer, with redirect, halt and out-of-range stop.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 16'h1000
`endif
`ifndef ROM_SIZE
`define ROM_SIZE 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module rom_fetch_ctrl
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int                     BUF_DEPTH = 2,
   parameter logic [`ADDR_WIDTH-1:0] RST_PC    = `ADDR_INIT
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_fetch_en,
   input  logic                   i_halt,
   input  logic                   i_redirect,
   input  logic [`ADDR_WIDTH-1:0] i_redirect_pc,
   output logic                   o_rom_rd_en,
   output logic [`ADDR_WIDTH-1:0] o_rom_rd_addr,
   input  logic [`INST_WIDTH-1:0] i_rom_rd_data,
   output logic                   o_inst_valid,
   input  logic                   i_inst_ready,
   output logic [`INST_WIDTH-1:0] o_inst,
   output logic [`ADDR_WIDTH-1:0] o_inst_pc,
   output logic                   o_inst_err,
   output logic                   o_halted,
   output logic [`ADDR_WIDTH-1:0] o_pc
);

   localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   fetch_state_t           state_q, state_d;
   logic [`ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                   err_stop_q, err_stop_d;

   logic [CNT_W-1:0]       count_s;
   fetch_entry_t           head_s;
   fetch_entry_t           push_entry_s;
   logic                   in_range_s;
   logic                   inst_valid_s;
   logic                   pop_s;
   logic                   push_s;
   logic                   flush_s;
   logic                   issue_s;

   // Halt outranks redirect, which outranks issue; the RUN/IDLE choice follows i_fetch_en.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      err_stop_d   = err_stop_q;
      flush_s      = 1'b0;
      push_s       = 1'b0;
      issue_s      = 1'b0;
      in_range_s   = pc_in_rom(pc_q);
      inst_valid_s = (count_s != {CNT_W{1'b0}}) && (state_q != HALT);
      pop_s        = inst_valid_s && i_inst_ready;
      push_entry_s = '{pc: pc_q, inst: (in_range_s ? i_rom_rd_data : `DATA_ZERO), err: !in_range_s};
      case (state_q)
         IDLE, RUN: begin
            if (i_halt) begin
               state_d = HALT;
               flush_s = 1'b1;
            end else begin
               state_d = i_fetch_en ? RUN : IDLE;
               if (i_redirect) begin
                  flush_s    = 1'b1;
                  err_stop_d = 1'b0;
                  pc_d       = i_redirect_pc & ALIGN_MASK;
               end else if ((state_q == RUN) && !err_stop_q && ((count_s < DEPTH_C) || pop_s)) begin
                  issue_s = 1'b1;
                  push_s  = 1'b1;
                  if (in_range_s) begin
                     pc_d = pc_q + PC_STEP;
                  end else begin
                     err_stop_d = 1'b1;
                  end
               end else begin
                  issue_s = 1'b0;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
            flush_s = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RST_PC;
         err_stop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         err_stop_q <= err_stop_d;
      end
   end

   rom_fetch_ctrl_fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push_s),
      .i_pop   (pop_s),
      .i_flush (flush_s),
      .i_entry (push_entry_s),
      .o_count (count_s),
      .o_head  (head_s)
   );

   assign o_rom_rd_en   = issue_s && in_range_s;
   assign o_rom_rd_addr = pc_q;
   assign o_pc          = pc_q;
   assign o_inst_valid  = inst_valid_s;
   assign o_inst        = head_s.inst;
   assign o_inst_pc     = head_s.pc;
   assign o_inst_err    = head_s.err;
   assign o_halted      = (state_q == HALT);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl against a queue-based fetch model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 16'h1000
`endif
`ifndef ROM_SIZE
`define ROM_SIZE 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module tb_rom_fetch_ctrl;

   localparam int AW    = `ADDR_WIDTH;
   localparam int IW    = `INST_WIDTH;
   localparam int DEPTH = 2;
   localparam int ROMW  = `ROM_SIZE;
   localparam logic [AW-1:0] BASE = `ADDR_INIT;
   localparam int OBS_W = 1 + AW + 1 + AW + IW + 1 + 1 + AW;
   localparam logic [OBS_W-1:0] RST_VEC = {1'b0, BASE, 1'b0, {AW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0, BASE};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_en = 1'b0;
   logic          halt = 1'b0;
   logic          redirect = 1'b0;
   logic          ready = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          rd_en, valid, err, halted;
   logic [AW-1:0] rd_addr, inst_pc, pc;
   logic [IW-1:0] rd_data, inst;
   logic [IW-1:0] rom [ROMW];
   int            total = 0;
   int            bad = 0;

   typedef struct { logic [AW-1:0] pc; logic [IW-1:0] inst; logic err; } ent_t;
   ent_t          mq[$];
   int            m_mode;     // 0 idle, 1 running, 2 halted
   logic [AW-1:0] m_pc;
   bit            m_stop;

   always #5 clk = ~clk;

   function automatic bit in_rom(input logic [AW-1:0] a);
      int off = int'(a) - int'(BASE);
      return (off >= 0) && (off < ROMW * 4);
   endfunction

   assign rd_data = in_rom(rd_addr) ? rom[(int'(rd_addr) - int'(BASE)) / 4] : 32'hDEAD_BEEF;

   wire [OBS_W-1:0] obs = {rd_en, rd_addr, valid, inst_pc, inst, err, halted, pc};

   rom_fetch_ctrl #(.BUF_DEPTH(DEPTH), .RST_PC(BASE)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_fetch_en(fetch_en), .i_halt(halt),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_rom_rd_en(rd_en), .o_rom_rd_addr(rd_addr), .i_rom_rd_data(rd_data),
      .o_inst_valid(valid), .i_inst_ready(ready), .o_inst(inst), .o_inst_pc(inst_pc),
      .o_inst_err(err), .o_halted(halted), .o_pc(pc)
   );

   function automatic bit m_issue();
      return (m_mode == 1) && !redirect && !halt && !m_stop &&
             ((mq.size() < DEPTH) || ((mq.size() > 0) && ready));
   endfunction

   function automatic logic [OBS_W-1:0] m_expect();
      ent_t h = '{pc: '0, inst: '0, err: 1'b0};
      bit v = (mq.size() > 0) && (m_mode != 2);
      if (mq.size() > 0) h = mq[0];
      return {m_issue() && in_rom(m_pc), m_pc, v, h.pc, h.inst, h.err, m_mode == 2, m_pc};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_mode = 0;
      m_pc   = BASE;
      m_stop = 0;
   endtask

   task automatic model_edge();
      bit pop = (mq.size() > 0) && (m_mode != 2) && ready;
      bit iss = m_issue();
      if (m_mode == 2) begin
         m_mode = 2;
      end else if (halt) begin
         m_mode = 2;
         mq.delete();
      end else begin
         if (redirect) begin
            mq.delete();
            m_stop = 0;
            m_pc   = redirect_pc - (redirect_pc % 4);
         end else begin
            if (pop) void'(mq.pop_front());
            if (iss) begin
               if (in_rom(m_pc)) begin
                  mq.push_back('{pc: m_pc, inst: rom[(int'(m_pc) - int'(BASE)) / 4], err: 1'b0});
                  m_pc = m_pc + 4;
               end else begin
                  mq.push_back('{pc: m_pc, inst: '0, err: 1'b1});
                  m_stop = 1;
               end
            end
         end
         m_mode = fetch_en ? 1 : 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      total++;
      if (obs !== RST_VEC) begin bad++; $display("FAIL reset got=%h exp=%h", obs, RST_VEC); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      fetch_en = 1'b1; ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         if (i == 1) begin
            total++;
            if (rd_en !== 1'b1 || rd_addr !== BASE) begin bad++; $display("FAIL first_fetch got=%b/%h exp=1/%h", rd_en, rd_addr, BASE); end
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      int reads = 0;
      logic [AW-1:0] last_pc = '0;
      bit have_last = 0;
      fetch_en = 1'b0; ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      fetch_en = 1'b1; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rd_en === 1'b1) reads++;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
      total++;
      if (reads != DEPTH) begin bad++; $display("FAIL stall_reads got=%0d exp=%0d", reads, DEPTH); end
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL release cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         if (valid === 1'b1) begin
            if (have_last) begin
               total++;
               if (inst_pc !== last_pc + 4) begin bad++; $display("FAIL contiguous got=%h exp=%h", inst_pc, last_pc + 4); end
            end
            last_pc = inst_pc; have_last = 1;
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      ready = 1'b0;
      for (int i = 0; i < 2; i++) tick();
      redirect = 1'b1; redirect_pc = BASE + 16'h0043; ready = 1'b1;
      #1;
      total++;
      if (obs !== m_expect()) begin bad++; $display("FAIL redirect_cyc got=%h exp=%h", obs, m_expect()); end
      tick();
      redirect = 1'b0;
      #1;
      total++;
      if (valid !== 1'b0 || rd_addr !== BASE + 16'h0040) begin bad++; $display("FAIL redirect_after got=%b/%h exp=0/%h", valid, rd_addr, BASE + 16'h0040); end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL redirect_run cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
   endtask

   task automatic test_range_end();
      bit saw_err = 0;
      logic [AW-1:0] end_pc = BASE + AW'(ROMW * 4);
      redirect = 1'b1; redirect_pc = end_pc - 16'd8; ready = 1'b1; fetch_en = 1'b1;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL range cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         if (valid === 1'b1 && err === 1'b1 && inst === `DATA_ZERO && inst_pc === end_pc) saw_err = 1;
         tick();
      end
      total++;
      if (!saw_err) begin bad++; $display("FAIL range_err_entry got=0 exp=1"); end
      redirect = 1'b1; redirect_pc = BASE;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL range_resume cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         fetch_en    = ($urandom_range(9) != 0);
         ready       = $urandom_range(1);
         redirect    = ($urandom_range(15) == 0);
         redirect_pc = AW'(int'(BASE) - 16 + int'($urandom_range(ROMW * 4 + 32)));
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
      redirect = 1'b0;
   endtask

   task automatic test_halt();
      fetch_en = 1'b1; ready = 1'b1; redirect = 1'b1; redirect_pc = BASE;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      halt = 1'b1; redirect = 1'b1; redirect_pc = BASE + 16'd8;
      #1;
      total++;
      if (obs !== m_expect()) begin bad++; $display("FAIL halt_cyc got=%h exp=%h", obs, m_expect()); end
      tick();
      halt = 1'b0; redirect = 1'b0;
      #1;
      total++;
      if (halted !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL halt_state got=%b/%b exp=1/0", halted, valid); end
      for (int i = 0; i < 10; i++) begin
         fetch_en    = $urandom_range(1);
         ready       = $urandom_range(1);
         redirect    = $urandom_range(1);
         redirect_pc = AW'(int'(BASE) + 4 * int'($urandom_range(ROMW - 1)));
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL halt_hold cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
      redirect = 1'b0;
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; fetch_en = 1'b1; ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== RST_VEC) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, RST_VEC); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (obs !== m_expect()) begin bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, m_expect()); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < ROMW; i++) rom[i] = $urandom;
      model_reset();
      test_reset();
      test_stream();
      test_back_pressure();
      test_redirect();
      test_range_end();
      test_random();
      test_halt();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
